// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous-read instruction SRAM,
// presents fetched instructions to decode and applies branch/jump redirects and stalls.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_pc,
  input  logic [7:0]  br_disp,
  input  logic        jmp_taken,
  input  logic [15:0] jmp_target,
  output logic        imem_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] inst_out,
  output logic [15:0] inst_pc,
  output logic [15:0] link_pc,
  output logic        inst_valid
);

  localparam int unsigned W  = 16;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {BOOT, RUN, HOLD, FLUSH} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   pc_q, pc_d;
  logic [W-1:0]   f_pc_q, f_pc_d;
  logic [W-1:0]   hold_q, hold_d;
  logic           hold_sel_q, hold_sel_d;
  logic           valid_q, valid_d;
  logic           redirect;
  logic [W-1:0]   target;
  logic [W-1:0]   pc_inc;

  assign redirect = br_taken | jmp_taken;
  assign target   = jmp_taken ? jmp_target
                              : W'(br_pc + {{(W-DW){br_disp[DW-1]}}, br_disp});
  assign pc_inc   = W'(pc_q + W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      f_pc_q     <= RESET_PC;
      hold_q     <= '0;
      hold_sel_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      f_pc_q     <= f_pc_d;
      hold_q     <= hold_d;
      hold_sel_q <= hold_sel_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state and SRAM enable; a redirect pre-empts every state, including a stall.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    f_pc_d     = f_pc_q;
    hold_d     = hold_q;
    hold_sel_d = hold_sel_q;
    valid_d    = valid_q;
    imem_en    = 1'b0;
    if (redirect) begin
      imem_en    = 1'b1;
      pc_d       = target;
      valid_d    = 1'b0;
      hold_sel_d = 1'b0;
      state_d    = FLUSH;
    end else begin
      case (state_q)
        BOOT, FLUSH: begin
          imem_en = 1'b1;
          f_pc_d  = pc_q;
          pc_d    = pc_inc;
          valid_d = 1'b1;
          state_d = RUN;
        end
        RUN: begin
          if (stall) begin
            // pc_q is not advanced, so the same address is re-issued on release
            hold_d     = imem_rdata;
            hold_sel_d = 1'b1;
            state_d    = HOLD;
          end else begin
            imem_en = 1'b1;
            f_pc_d  = pc_q;
            pc_d    = pc_inc;
            valid_d = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            imem_en    = 1'b1;
            f_pc_d     = pc_q;
            pc_d       = pc_inc;
            valid_d    = 1'b1;
            hold_sel_d = 1'b0;
            state_d    = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
    end
    if (rst) imem_en = 1'b0;
  end

  assign imem_addr  = pc_q;
  assign inst_out   = rst ? '0 : (hold_sel_q ? hold_q : imem_rdata);
  assign inst_pc    = f_pc_q;
  assign link_pc    = W'(f_pc_q + W'(1));
  assign inst_valid = valid_q & ~redirect;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against a cycle-level model of the presented instruction stream.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_pc;
  logic [7:0]  br_disp;
  logic        jmp_taken;
  logic [15:0] jmp_target;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic [15:0] inst_out;
  logic [15:0] inst_pc;
  logic [15:0] link_pc;
  logic        inst_valid;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_pc      (br_pc),
    .br_disp    (br_disp),
    .jmp_taken  (jmp_taken),
    .jmp_target (jmp_target),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .link_pc    (link_pc),
    .inst_valid (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read SRAM whose word at addr holds 0x0100 + addr
  always @(posedge clk) if (imem_en) imem_rdata <= 16'(16'h0100 + imem_addr);

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; br_taken = 1'b0; br_pc = '0; br_disp = '0;
    jmp_taken = 1'b0; jmp_target = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    #1;
    n_cmp++;
    if ({imem_en, inst_valid, inst_out, inst_pc, link_pc, imem_addr} !==
        {1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_outputs: en=%b v=%b out=%h pc=%h link=%h addr=%h, want 0 0 0000 0000 0001 0000",
               imem_en, inst_valid, inst_out, inst_pc, link_pc, imem_addr);
    end
  endtask

  task automatic test_boot();
    tick(); rst = 1'b0; #1;
    n_cmp++;
    if ({imem_en, imem_addr, inst_valid} !== {1'b1, 16'h0000, 1'b0}) begin
      n_err++;
      $display("FAIL boot_cycle1: en=%b addr=%h v=%b, want 1 0000 0", imem_en, imem_addr, inst_valid);
    end
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      n_cmp++;
      if ({inst_valid, inst_pc, inst_out} !== {1'b1, 16'(i), 16'(16'h0100 + i)}) begin
        n_err++;
        $display("FAIL boot_seq%0d: v=%b pc=%h out=%h, want 1 %h %h",
                 i, inst_valid, inst_pc, inst_out, 16'(i), 16'(16'h0100 + i));
      end
    end
  endtask

  // Entered while pc 5 is being presented; stall covers that cycle and the next two.
  task automatic test_stall();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      stall = (c < 3); #1;
      n_cmp++;
      if ({inst_valid, inst_pc, inst_out, imem_addr} !== {1'b1, 16'h0005, 16'h0105, 16'h0006}) begin
        n_err++;
        $display("FAIL stall_hold%0d: v=%b pc=%h out=%h addr=%h, want 1 0005 0105 0006",
                 c, inst_valid, inst_pc, inst_out, imem_addr);
      end
      if (c == 1 || c == 2 || c == 3) begin
        n_cmp++;
        if (imem_en !== (c == 3)) begin
          n_err++;
          $display("FAIL stall_en%0d: en=%b want %b", c, imem_en, (c == 3));
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      n_cmp++;
      if ({inst_valid, inst_pc, inst_out} !== {1'b1, 16'(6 + c), 16'(16'h0106 + c)}) begin
        n_err++;
        $display("FAIL stall_resume%0d: v=%b pc=%h out=%h, want 1 %h %h",
                 c, inst_valid, inst_pc, inst_out, 16'(6 + c), 16'(16'h0106 + c));
      end
    end
  endtask

  task automatic test_branch();
    tick(); br_taken = 1'b1; br_pc = 16'h0010; br_disp = 8'hF0; #1;
    n_cmp++;
    if (inst_valid !== 1'b0) begin n_err++; $display("FAIL br_squash: v=%b want 0", inst_valid); end
    tick(); idle_inputs(); #1;
    n_cmp++;
    if (inst_valid !== 1'b0) begin n_err++; $display("FAIL br_bubble: v=%b want 0", inst_valid); end
    tick(); #1;
    n_cmp++;
    if ({inst_valid, inst_pc, inst_out} !== {1'b1, 16'h0000, 16'h0100}) begin
      n_err++;
      $display("FAIL br_target: v=%b pc=%h out=%h, want 1 0000 0100", inst_valid, inst_pc, inst_out);
    end
  endtask

  task automatic test_jump(input logic [15:0] tgt);
    logic [15:0] nxt;
    nxt = 16'(tgt + 16'h0001);
    tick(); jmp_taken = 1'b1; jmp_target = tgt; #1;
    n_cmp++;
    if (inst_valid !== 1'b0) begin n_err++; $display("FAIL jmp_squash: v=%b want 0", inst_valid); end
    tick(); idle_inputs(); #1;
    n_cmp++;
    if (inst_valid !== 1'b0) begin n_err++; $display("FAIL jmp_bubble: v=%b want 0", inst_valid); end
    tick(); #1;
    n_cmp++;
    if ({inst_valid, inst_pc, inst_out, link_pc} !== {1'b1, tgt, 16'(16'h0100 + tgt), nxt}) begin
      n_err++;
      $display("FAIL jmp_target: v=%b pc=%h out=%h link=%h, want 1 %h %h %h",
               inst_valid, inst_pc, inst_out, link_pc, tgt, 16'(16'h0100 + tgt), nxt);
    end
    tick(); #1;
    n_cmp++;
    if ({inst_valid, inst_pc, link_pc} !== {1'b1, nxt, 16'(nxt + 16'h0001)}) begin
      n_err++;
      $display("FAIL jmp_next: v=%b pc=%h link=%h, want 1 %h %h",
               inst_valid, inst_pc, link_pc, nxt, 16'(nxt + 16'h0001));
    end
  endtask

  task automatic test_simultaneous();
    tick(); stall = 1'b1; br_taken = 1'b1; br_pc = 16'h0020; br_disp = 8'h00; #1;
    n_cmp++;
    if ({inst_valid, imem_en} !== 2'b01) begin
      n_err++;
      $display("FAIL stall_br_cycle: v=%b en=%b, want 0 1", inst_valid, imem_en);
    end
    tick(); idle_inputs(); tick(); #1;
    n_cmp++;
    if ({inst_valid, inst_pc, inst_out} !== {1'b1, 16'h0020, 16'h0120}) begin
      n_err++;
      $display("FAIL stall_br_target: v=%b pc=%h out=%h, want 1 0020 0120", inst_valid, inst_pc, inst_out);
    end
    tick(); #1;
    n_cmp++;
    if ({inst_valid, inst_pc, inst_out} !== {1'b1, 16'h0021, 16'h0121}) begin
      n_err++;
      $display("FAIL stall_br_nohold: v=%b pc=%h out=%h, want 1 0021 0121", inst_valid, inst_pc, inst_out);
    end
    tick(); br_taken = 1'b1; br_pc = 16'h0100; br_disp = 8'h05;
    jmp_taken = 1'b1; jmp_target = 16'h0030;
    tick(); idle_inputs(); tick(); #1;
    n_cmp++;
    if ({inst_valid, inst_pc, inst_out} !== {1'b1, 16'h0030, 16'h0130}) begin
      n_err++;
      $display("FAIL jmp_priority: v=%b pc=%h out=%h, want 1 0030 0130", inst_valid, inst_pc, inst_out);
    end
  endtask

  task automatic test_mid_reset();
    tick(); stall = 1'b1;
    tick(); #1;
    n_cmp++;
    if (imem_en !== 1'b0) begin n_err++; $display("FAIL midrst_inhold: en=%b want 0", imem_en); end
    #1 rst = 1'b1; #1;
    n_cmp++;
    if ({imem_en, inst_valid, inst_out, inst_pc, link_pc, imem_addr} !==
        {1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0000}) begin
      n_err++;
      $display("FAIL midrst_async: en=%b v=%b out=%h pc=%h link=%h addr=%h, want 0 0 0000 0000 0001 0000",
               imem_en, inst_valid, inst_out, inst_pc, link_pc, imem_addr);
    end
    tick(); stall = 1'b0;
    test_boot();
  endtask

  // Model: the stream is a PC plus a count of bubble cycles still to come.
  task automatic test_random();
    logic [15:0] cur, tgt;
    int          bub, sum;
    logic        redir, exp_v;
    tick(); rst = 1'b1; idle_inputs();
    tick(); rst = 1'b0;
    cur = 16'h0000; bub = 1;
    for (int i = 0; i < 2000; i++) begin
      stall      = ($urandom_range(0, 9) < 3);
      br_taken   = ($urandom_range(0, 99) < 6);
      jmp_taken  = ($urandom_range(0, 99) < 4);
      br_pc      = 16'($urandom);
      br_disp    = 8'($urandom);
      jmp_target = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + $urandom_range(0, 1)) : 16'($urandom);
      #1;
      redir = br_taken | jmp_taken;
      sum   = jmp_taken ? int'(jmp_target) : int'(br_pc) + int'($signed(br_disp));
      tgt   = sum[15:0];
      exp_v = (bub == 0) && !redir;
      n_cmp++;
      if (inst_valid !== exp_v) begin
        n_err++;
        $display("FAIL rand_valid@%0d: v=%b want %b", i, inst_valid, exp_v);
      end
      if (bub == 0) begin
        n_cmp++;
        if ({inst_pc, inst_out, link_pc} !== {cur, 16'(16'h0100 + cur), 16'(cur + 16'h0001)}) begin
          n_err++;
          $display("FAIL rand_inst@%0d: pc=%h out=%h link=%h, want %h %h %h", i, inst_pc, inst_out,
                   link_pc, cur, 16'(16'h0100 + cur), 16'(cur + 16'h0001));
        end
      end
      if (redir) begin
        cur = tgt; bub = 1;
      end else if (bub > 0) begin
        bub--;
      end else if (!stall) begin
        cur = 16'(cur + 16'h0001);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall();
    test_branch();
    test_jump(16'h0040);
    test_jump(16'hFFFF);
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
